// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared state encoding, default widths and entry layout for sdram_cmd_queue
package sdram_pkg;

    typedef enum logic [1:0] {
        S_WAIT_INIT = 2'd0,
        S_IDLE      = 2'd1,
        S_ISSUE     = 2'd2,
        S_GAP       = 2'd3
    } state_e;

    localparam int ADDR_W_DEF = 22;
    localparam int DATA_W_DEF = 128;

    // Queue entry is packed as {write, address, data} with data in the low bits.
    localparam int ENTRY_DATA_LSB = 0;

    function automatic int entry_addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int entry_write_bit(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/sdram_cmd_fifo.sv
// rtl/sdram_cmd_fifo.sv - small synchronous FIFO with occupancy count and full/empty flags
module sdram_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 151
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sdram_cmd_queue.sv
// rtl/sdram_cmd_queue.sv - in-order host command queue issuing one req/ack command at a time to the SDRAM controller
module sdram_cmd_queue
    import sdram_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       iclk,
    input  logic                       ireset_n,
    input  logic                       icmd_valid,
    input  logic                       icmd_write,
    input  logic [ADDR_W-1:0]          icmd_address,
    input  logic [DATA_W-1:0]          icmd_data,
    output logic                       ocmd_ready,
    output logic                       orsp_valid,
    output logic                       orsp_write,
    output logic [DATA_W-1:0]          orsp_data,
    input  logic                       iinit_done,
    output logic                       owrite_req,
    output logic                       oread_req,
    output logic [ADDR_W-1:0]          oaddress,
    output logic [DATA_W-1:0]          owrite_data,
    input  logic                       iwrite_ack,
    input  logic                       iread_ack,
    input  logic [DATA_W-1:0]          iread_data,
    output logic [$clog2(DEPTH+1)-1:0] ocount,
    output logic                       oerror
);

    localparam int ENTRY_W  = 1 + ADDR_W + DATA_W;
    localparam int ADDR_LSB = entry_addr_lsb(DATA_W);
    localparam int WR_BIT   = entry_write_bit(ADDR_W, DATA_W);
    localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e              state_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                err_q;
    logic                rsp_valid_q;
    logic                rsp_write_q;
    logic [DATA_W-1:0]   rsp_data_q;

    logic [ENTRY_W-1:0]  head;
    logic                head_write;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                issue;
    logic                wr_match;
    logic                rd_match;
    logic                pop;
    logic                bad_ack;

    sdram_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (iclk),
        .rst_ni  (ireset_n),
        .push_i  (push),
        .wdata_i ({icmd_write, icmd_address, icmd_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (ocount),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ocmd_ready = (state_q != S_WAIT_INIT) & ~fifo_full;
    assign push       = icmd_valid & ocmd_ready;

    assign head_write = head[WR_BIT];
    assign issue      = (state_q == S_ISSUE);
    assign wr_match   = issue & head_write & iwrite_ack;
    assign rd_match   = issue & ~head_write & iread_ack;
    assign pop        = wr_match | rd_match;
    // Any ack that does not complete the current head is a protocol error.
    assign bad_ack    = (iwrite_ack & ~wr_match) | (iread_ack & ~rd_match);

    // Reqs drop combinationally in the ack cycle so the controller never sees a repeat.
    assign owrite_req  = issue & head_write & ~iwrite_ack;
    assign oread_req   = issue & ~head_write & ~iread_ack;
    assign oaddress    = issue ? head[ADDR_LSB +: ADDR_W] : '0;
    assign owrite_data = issue ? head[ENTRY_DATA_LSB +: DATA_W] : '0;

    assign orsp_valid = rsp_valid_q;
    assign orsp_write = rsp_write_q;
    assign orsp_data  = rsp_data_q;
    assign oerror     = err_q;

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q     <= S_WAIT_INIT;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                S_WAIT_INIT: if (iinit_done) state_q <= S_IDLE;
                S_IDLE:      if (!fifo_empty) state_q <= S_ISSUE;
                S_ISSUE:     if (pop) state_q <= S_GAP;
                S_GAP:       state_q <= fifo_empty ? S_IDLE : S_ISSUE;
                default:     state_q <= S_WAIT_INIT;
            endcase

            // Cycles spent waiting on the current command; saturates at the limit.
            if (issue) begin
                if (tmo_q != TMO_MAX) tmo_q <= tmo_q + 1'b1;
            end else begin
                tmo_q <= '0;
            end

            if (bad_ack || (issue && tmo_q == TMO_LAST)) err_q <= 1'b1;

            rsp_valid_q <= pop;
            rsp_write_q <= wr_match;
            rsp_data_q  <= rd_match ? iread_data : '0;
        end
    end

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// tb/tb_sdram_cmd_queue.sv - directed self-checking bench for sdram_cmd_queue
module tb_sdram_cmd_queue;

    logic         iclk = 1'b0;
    logic         ireset_n;
    logic         icmd_valid;
    logic         icmd_write;
    logic [21:0]  icmd_address;
    logic [127:0] icmd_data;
    logic         ocmd_ready;
    logic         orsp_valid;
    logic         orsp_write;
    logic [127:0] orsp_data;
    logic         iinit_done;
    logic         owrite_req;
    logic         oread_req;
    logic [21:0]  oaddress;
    logic [127:0] owrite_data;
    logic         iwrite_ack;
    logic         iread_ack;
    logic [127:0] iread_data;
    logic [2:0]   ocount;
    logic         oerror;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] WDATA = 128'hDEADBEEF_00000000_11111111_DEADBEEF;
    localparam logic [127:0] RDATA = 128'h01234567_89ABCDEF_01234567_89ABCDEF;

    always #5 iclk = ~iclk;

    sdram_cmd_queue dut (
        .iclk         (iclk),
        .ireset_n     (ireset_n),
        .icmd_valid   (icmd_valid),
        .icmd_write   (icmd_write),
        .icmd_address (icmd_address),
        .icmd_data    (icmd_data),
        .ocmd_ready   (ocmd_ready),
        .orsp_valid   (orsp_valid),
        .orsp_write   (orsp_write),
        .orsp_data    (orsp_data),
        .iinit_done   (iinit_done),
        .owrite_req   (owrite_req),
        .oread_req    (oread_req),
        .oaddress     (oaddress),
        .owrite_data  (owrite_data),
        .iwrite_ack   (iwrite_ack),
        .iread_ack    (iread_ack),
        .iread_data   (iread_data),
        .ocount       (ocount),
        .oerror       (oerror)
    );

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic wr, input logic [21:0] addr, input logic [127:0] data);
        icmd_valid   = 1'b1;
        icmd_write   = wr;
        icmd_address = addr;
        icmd_data    = data;
        tick();
        icmd_valid   = 1'b0;
    endtask

    initial begin
        ireset_n     = 1'b0;
        icmd_valid   = 1'b0;
        icmd_write   = 1'b0;
        icmd_address = '0;
        icmd_data    = '0;
        iinit_done   = 1'b0;
        iwrite_ack   = 1'b0;
        iread_ack    = 1'b0;
        iread_data   = '0;

        #2;
        chk("rst_ready",   ocmd_ready,  0);
        chk("rst_rsp_v",   orsp_valid,  0);
        chk("rst_rsp_w",   orsp_write,  0);
        chk("rst_rsp_d",   orsp_data,   0);
        chk("rst_wreq",    owrite_req,  0);
        chk("rst_rreq",    oread_req,   0);
        chk("rst_addr",    oaddress,    0);
        chk("rst_wdata",   owrite_data, 0);
        chk("rst_count",   ocount,      0);
        chk("rst_err",     oerror,      0);
        tick();
        tick();
        ireset_n = 1'b1;

        // Init gating: pushes are refused until init completes.
        icmd_valid = 1'b1;
        icmd_write = 1'b1;
        tick();
        tick();
        chk("init_ready0", ocmd_ready, 0);
        chk("init_count0", ocount,     0);
        chk("init_wreq0",  owrite_req, 0);
        icmd_valid = 1'b0;
        iinit_done = 1'b1;
        #1;
        chk("init_ready_same", ocmd_ready, 0);
        tick();
        chk("init_ready1", ocmd_ready, 1);

        // Single write.
        push_cmd(1'b1, 22'h0A5A5, WDATA);
        chk("w_count1", ocount,     1);
        chk("w_req_c1", owrite_req, 0);
        tick();
        chk("w_req",    owrite_req,  1);
        chk("w_rreq",   oread_req,   0);
        chk("w_addr",   oaddress,    22'h0A5A5);
        chk("w_data",   owrite_data, WDATA);
        tick();
        chk("w_req_hold",  owrite_req,  1);
        chk("w_addr_hold", oaddress,    22'h0A5A5);
        chk("w_data_hold", owrite_data, WDATA);
        iwrite_ack = 1'b1;
        #1;
        chk("w_req_ackcyc", owrite_req, 0);
        tick();
        iwrite_ack = 1'b0;
        chk("w_rsp_v",  orsp_valid, 1);
        chk("w_rsp_w",  orsp_write, 1);
        chk("w_rsp_d",  orsp_data,  0);
        chk("w_count0", ocount,     0);
        chk("w_gap",    owrite_req, 0);
        tick();
        chk("w_rsp_pulse", orsp_valid, 0);

        // Single read.
        push_cmd(1'b0, 22'h3FFFF, '0);
        tick();
        chk("r_req",  oread_req,  1);
        chk("r_wreq", owrite_req, 0);
        chk("r_addr", oaddress,   22'h3FFFF);
        iread_ack  = 1'b1;
        iread_data = RDATA;
        #1;
        chk("r_req_ackcyc", oread_req, 0);
        tick();
        iread_ack  = 1'b0;
        iread_data = '0;
        chk("r_rsp_v", orsp_valid, 1);
        chk("r_rsp_w", orsp_write, 0);
        chk("r_rsp_d", orsp_data,  RDATA);
        tick();
        chk("r_err", oerror, 0);

        // Fill to DEPTH with acks held off: W,R,W,R.
        for (int k = 0; k < 4; k++) begin
            icmd_valid   = 1'b1;
            icmd_write   = (k % 2 == 0);
            icmd_address = 22'(k + 1);
            icmd_data    = 128'(k + 1) * 128'h1111;
            tick();
        end
        chk("fill_count", ocount,     4);
        chk("fill_ready", ocmd_ready, 0);
        chk("fill_head",  oaddress,   22'd1);
        icmd_address = 22'd9;
        tick();
        icmd_valid = 1'b0;
        chk("fill_nopush", ocount, 4);

        for (int k = 0; k < 4; k++) begin
            logic is_wr;
            is_wr = (k % 2 == 0);
            chk($sformatf("dr%0d_wreq", k), owrite_req, is_wr);
            chk($sformatf("dr%0d_rreq", k), oread_req,  !is_wr);
            chk($sformatf("dr%0d_addr", k), oaddress,   22'(k + 1));
            if (is_wr) chk($sformatf("dr%0d_wdata", k), owrite_data, 128'(k + 1) * 128'h1111);
            iwrite_ack = is_wr;
            iread_ack  = !is_wr;
            iread_data = 128'hA000 + 128'(k);
            tick();
            iwrite_ack = 1'b0;
            iread_ack  = 1'b0;
            iread_data = '0;
            chk($sformatf("dr%0d_rsp_v", k), orsp_valid, 1);
            chk($sformatf("dr%0d_rsp_w", k), orsp_write, is_wr);
            chk($sformatf("dr%0d_rsp_d", k), orsp_data,  is_wr ? 128'h0 : 128'hA000 + 128'(k));
            chk($sformatf("dr%0d_gap", k),   owrite_req | oread_req, 0);
            chk($sformatf("dr%0d_cnt", k),   ocount, 3'(3 - k));
            tick();
        end
        chk("dr_idle_rsp", orsp_valid, 0);
        chk("dr_idle_req", owrite_req | oread_req, 0);

        // Wrapped pointers: one more command after the pointers lap.
        push_cmd(1'b1, 22'h00055, 128'h5555);
        tick();
        chk("wrap_addr",  oaddress,    22'h00055);
        chk("wrap_wdata", owrite_data, 128'h5555);
        iwrite_ack = 1'b1;
        tick();
        iwrite_ack = 1'b0;
        chk("wrap_rsp", orsp_valid, 1);
        tick();

        // Mismatched ack on a write head.
        push_cmd(1'b1, 22'h00006, 128'h6);
        tick();
        chk("mm_req", owrite_req, 1);
        iread_ack = 1'b1;
        #1;
        chk("mm_req_ackcyc", owrite_req, 1);
        tick();
        iread_ack = 1'b0;
        chk("mm_err",   oerror,     1);
        chk("mm_count", ocount,     1);
        chk("mm_rsp",   orsp_valid, 0);
        chk("mm_req2",  owrite_req, 1);
        tick();
        chk("mm_sticky", oerror, 1);

        // Reset while a command is being issued.
        ireset_n = 1'b0;
        #1;
        chk("mr_wreq",  owrite_req, 0);
        chk("mr_err",   oerror,     0);
        chk("mr_count", ocount,     0);
        chk("mr_addr",  oaddress,   0);
        chk("mr_ready", ocmd_ready, 0);
        #10;
        ireset_n = 1'b1;
        #1;
        chk("mr_wait_ready", ocmd_ready, 0);
        tick();
        chk("mr_ready1", ocmd_ready, 1);
        chk("mr_norsp",  orsp_valid, 0);
        chk("mr_noreq",  owrite_req | oread_req, 0);
        chk("mr_count0", ocount, 0);

        // Timeout: no ack for TIMEOUT_CYC cycles in issue.
        push_cmd(1'b0, 22'h00007, '0);
        tick();
        chk("to_req", oread_req, 1);
        repeat (1023) tick();
        chk("to_err_early", oerror, 0);
        tick();
        chk("to_err",      oerror,    1);
        chk("to_req_held", oread_req, 1);
        iread_ack  = 1'b1;
        iread_data = 128'hCAFE;
        tick();
        iread_ack  = 1'b0;
        iread_data = '0;
        chk("to_rsp_v", orsp_valid, 1);
        chk("to_rsp_d", orsp_data,  128'hCAFE);
        chk("to_count", ocount,     0);
        chk("to_err_sticky", oerror, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
